// File: rtl/counter_clk_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_clk_ctrl_if
// Configuration channel of the divided-clock controller.
//   cfg_valid  : requester offers a new setting
//   cfg_ready  : controller can take a setting this cycle
//   cfg_c0     : new half-period count minus 1
//   cfg_enable : 1 = run with cfg_c0, 0 = stop after the current period
//   cfg_done   : one-cycle pulse once an accepted setting has taken effect
// master = requester, slave = controller.
// ----------------------------------------------------------------------------
interface counter_clk_ctrl_if #(
  parameter int DIV_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_c0;
  logic             cfg_enable;
  logic             cfg_done;

  modport master (
    output cfg_valid, cfg_c0, cfg_enable,
    input  cfg_ready, cfg_done
  );

  modport slave (
    input  cfg_valid, cfg_c0, cfg_enable,
    output cfg_ready, cfg_done
  );
endinterface

// File: rtl/counter_clk_ctrl.sv
// ----------------------------------------------------------------------------
// counter_clk_ctrl
// Runtime-programmable counter divider producing a registered fabric clock
// level from refclk. New settings arrive on a valid/ready channel and are
// applied only on the falling toggle that completes an output period, so the
// output never shows a runt phase (other than one truncated by reset).
//
// Ports:
//   refclk   in   reference clock, the only clock
//   rst_n    in   asynchronous active-low reset
//   cfg      if   configuration channel (slave side)
//   clk_o    out  divided clock level, registered
//   rise_stb out  high the cycle clk_o has just become 1
//   fall_stb out  high the cycle clk_o has just become 0
//   running  out  state is RUN or PEND
//   cur_c0   out  half-period count minus 1 currently in effect
// ----------------------------------------------------------------------------
module counter_clk_ctrl #(
  parameter int DIV_W         = 16,
  parameter int DEFAULT_C0    = 11,
  parameter bit START_ENABLED = 1'b1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  counter_clk_ctrl_if.slave     cfg,
  output logic                  clk_o,
  output logic                  rise_stb,
  output logic                  fall_stb,
  output logic                  running,
  output logic [DIV_W-1:0]      cur_c0
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam state_t RESET_STATE = START_ENABLED ? ST_RUN : ST_STOP;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_cur_c0;
  logic [DIV_W-1:0] r_pend_c0;
  logic             r_pend_en;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             r_done;

  // End of a half period: the counter has reached the programmed count.
  logic w_wrap;
  assign w_wrap = (r_cnt == r_cur_c0);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET_STATE;
      r_cnt     <= '0;
      r_cur_c0  <= DIV_W'(DEFAULT_C0);
      r_pend_c0 <= '0;
      r_pend_en <= 1'b0;
      r_clk     <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // values of each other; blocking '=' would make the order of these
      // statements change the hardware.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_done <= 1'b0;

      unique case (r_state)
        ST_STOP: begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          // Stopped: a setting takes effect on the very edge it is accepted.
          if (cfg.cfg_valid) begin
            r_cur_c0 <= cfg.cfg_c0;
            r_done   <= 1'b1;
            r_state  <= cfg.cfg_enable ? ST_RUN : ST_STOP;
          end
        end

        ST_RUN, ST_PEND: begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_rise <= ~r_clk;
            r_fall <= r_clk;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end

          // Running: park the request until the current period completes.
          if (r_state == ST_RUN && cfg.cfg_valid) begin
            r_pend_c0 <= cfg.cfg_c0;
            r_pend_en <= cfg.cfg_enable;
            r_state   <= ST_PEND;
          end

          // Apply only on the falling toggle, which closes a full period;
          // the counting branch above already drives clk low and clears cnt.
          if (r_state == ST_PEND && w_wrap && r_clk) begin
            r_cur_c0 <= r_pend_c0;
            r_done   <= 1'b1;
            r_state  <= r_pend_en ? ST_RUN : ST_STOP;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_clk   <= 1'b0;
          r_state <= ST_STOP;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = (r_state != ST_PEND);
  assign cfg.cfg_done  = r_done;
  assign clk_o         = r_clk;
  assign rise_stb      = r_rise;
  assign fall_stb      = r_fall;
  assign running       = (r_state != ST_STOP);
  assign cur_c0        = r_cur_c0;

endmodule
